// File: rtl/shift_reg_univ.sv
// Universal shift register: parallel load, logical shift and rotate in both
// directions, with a saturating shift counter and a one-cycle done pulse.
module shift_reg_univ #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       sin,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_msb,
  output logic                       sout_lsb,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       done
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;

  logic [WIDTH-1:0] q_reg, q_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] shl_vec, shr_vec, rol_vec, ror_vec;
  logic             shift_op;

  // Per-bit neighbour selection; the end bits take sin or the wrapped bit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (gi == 0) begin : g_lo
      assign shl_vec[gi] = sin;
      assign rol_vec[gi] = q_reg[WIDTH-1];
    end else begin : g_lo_n
      assign shl_vec[gi] = q_reg[gi-1];
      assign rol_vec[gi] = q_reg[gi-1];
    end
    if (gi == WIDTH - 1) begin : g_hi
      assign shr_vec[gi] = sin;
      assign ror_vec[gi] = q_reg[0];
    end else begin : g_hi_n
      assign shr_vec[gi] = q_reg[gi+1];
      assign ror_vec[gi] = q_reg[gi+1];
    end
  end

  assign shift_op = (mode == MODE_SHL) || (mode == MODE_SHR) ||
                    (mode == MODE_ROL) || (mode == MODE_ROR);

  always_comb begin
    q_next    = q_reg;
    cnt_next  = cnt_reg;
    done_next = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: q_next = q_reg;
        MODE_LOAD: begin
          q_next   = d;
          cnt_next = '0;
        end
        MODE_SHL:  q_next = shl_vec;
        MODE_SHR:  q_next = shr_vec;
        MODE_ROL:  q_next = rol_vec;
        MODE_ROR:  q_next = ror_vec;
        default:   q_next = q_reg;
      endcase
      if (shift_op) begin
        done_next = (cnt_reg == CNT_LAST);
        if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_reg    <= RESET_VAL;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      cnt_reg  <= cnt_next;
      done_reg <= done_next;
    end
  end

  assign q        = q_reg;
  assign cnt      = cnt_reg;
  assign done     = done_reg;
  assign sout_msb = q_reg[WIDTH-1];
  assign sout_lsb = q_reg[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: 4-bit and 8-bit instances driven together,
// directed scenarios plus random traffic against an arithmetic model.
module tb_shift_reg_univ;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'b000;
  logic       sin = 1'b0;
  logic [3:0] d4 = '0;
  logic [7:0] d8 = '0;

  logic [3:0] q4;
  logic [2:0] cnt4;
  logic       msb4, lsb4, done4;
  logic [7:0] q8;
  logic [3:0] cnt8;
  logic       msb8, lsb8, done8;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m4_q, m4_cnt, m4_done;
  int m8_q, m8_cnt, m8_done;

  always #5 clk = ~clk;

  shift_reg_univ #(.WIDTH(4), .RESET_VAL(4'h0)) dut4 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .d(d4), .sin(sin),
    .q(q4), .sout_msb(msb4), .sout_lsb(lsb4), .cnt(cnt4), .done(done4)
  );

  shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .d(d8), .sin(sin),
    .q(q8), .sout_msb(msb8), .sout_lsb(lsb8), .cnt(cnt8), .done(done8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int w, input int rv, input int r, input int e, input int m,
                       input int dv, input int s, inout int q, inout int c, inout int dn);
    int mask;
    mask = (1 << w) - 1;
    if (r == 0) begin
      q = rv; c = 0; dn = 0;
    end else if (e == 0) begin
      dn = 0;
    end else begin
      dn = 0;
      case (m)
        1: begin q = dv & mask; c = 0; end
        2: q = ((q << 1) | s) & mask;
        3: q = (q >> 1) | (s << (w - 1));
        4: q = ((q << 1) | (q >> (w - 1))) & mask;
        5: q = (q >> 1) | ((q & 1) << (w - 1));
        default: ;
      endcase
      if (m >= 2 && m <= 5) begin
        dn = (c == w - 1) ? 1 : 0;
        c  = (c < w) ? c + 1 : w;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare every output.
  task automatic step(input int r, input int e, input int m, input int dv4,
                      input int dv8, input int s);
    reset_n = r[0]; en = e[0]; mode = m[2:0]; d4 = dv4[3:0]; d8 = dv8[7:0]; sin = s[0];
    @(posedge clk);
    model(4, 0, r, e, m, dv4, s, m4_q, m4_cnt, m4_done);
    model(8, 'hA5, r, e, m, dv8, s, m8_q, m8_cnt, m8_done);
    #1;
    check("q4", 32'(q4), m4_q);
    check("cnt4", 32'(cnt4), m4_cnt);
    check("done4", 32'(done4), m4_done);
    check("msb4", 32'(msb4), (m4_q >> 3) & 1);
    check("lsb4", 32'(lsb4), m4_q & 1);
    check("q8", 32'(q8), m8_q);
    check("cnt8", 32'(cnt8), m8_cnt);
    check("done8", 32'(done8), m8_done);
    check("msb8", 32'(msb8), (m8_q >> 7) & 1);
    check("lsb8", 32'(lsb8), m8_q & 1);
    $display("step rst_n=%0d en=%0d mode=%0d sin=%0d q4=%h cnt4=%0d done4=%0d q8=%h cnt8=%0d done8=%0d",
             r, e, m, s, q4, cnt4, done4, q8, cnt8, done8);
  endtask

  initial begin
    int q_exp[5];
    int c_exp[5];
    int dn_exp[5];
    int pulses;
    int r, e, m;
    q_exp  = '{4'h6, 4'hC, 4'h8, 4'h0, 4'h0};
    c_exp  = '{1, 2, 3, 4, 4};
    dn_exp = '{0, 0, 0, 1, 0};
    m4_q = 0; m4_cnt = 0; m4_done = 0;
    m8_q = 0; m8_cnt = 0; m8_done = 0;

    // Initial reset and scenario 1
    step(0, 1, 2, 0, 0, 0);
    check("rst_q", 32'(q4), 0);
    step(1, 1, 1, 'hA, 'h3C, 0);
    check("ld_A", 32'(q4), 'hA);
    step(0, 1, 2, 0, 0, 1);
    check("rst_q2", 32'(q4), 0);
    check("rst_cnt", 32'(cnt4), 0);
    check("rst_done", 32'(done4), 0);
    check("rst_q8", 32'(q8), 'hA5);

    // Scenario 2: load and hold
    step(1, 1, 1, 'hB, 'h00, 0);
    check("ld_B", 32'(q4), 'hB);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 1);
    check("hold_q", 32'(q4), 'hB);
    check("hold_cnt", 32'(cnt4), 0);
    step(1, 1, 6, 0, 0, 1);
    check("rsv_q", 32'(q4), 'hB);

    // Scenario 3: shift left with done
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 2, 0, 0, 0);
      check("shl_q", 32'(q4), q_exp[i]);
      check("shl_cnt", 32'(cnt4), c_exp[i]);
      check("shl_done", 32'(done4), dn_exp[i]);
    end

    // Scenario 4: rotate and enable
    step(1, 1, 1, 'hB, 0, 0);
    step(1, 1, 5, 0, 0, 0);
    check("ror_q", 32'(q4), 'hD);
    for (int i = 0; i < 2; i++) step(1, 0, 2, 0, 0, 1);
    check("en0_q", 32'(q4), 'hD);
    check("en0_cnt", 32'(cnt4), 1);
    check("en0_done", 32'(done4), 0);
    step(1, 1, 4, 0, 0, 0);
    check("rol_q", 32'(q4), 'hB);

    // Scenario 5: reset mid-run
    step(1, 1, 1, 'hF, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 1, 3, 0, 0, 0);
    check("shr_q", 32'(q4), 'h3);
    check("shr_cnt", 32'(cnt4), 2);
    step(0, 0, 3, 0, 0, 0);
    check("mid_rst_q", 32'(q4), 0);
    check("mid_rst_cnt", 32'(cnt4), 0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 3, 0, 0, 1);
      pulses += int'(done4);
    end
    check("one_pulse", pulses, 1);

    // Scenario 6: 8-bit instance
    step(0, 1, 0, 0, 0, 0);
    check("rst8", 32'(q8), 'hA5);
    step(1, 1, 3, 0, 0, 1);
    check("shr8_q", 32'(q8), 'hD2);
    check("shr8_cnt", 32'(cnt8), 1);
    step(1, 1, 1, 0, 'h96, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 2 + (i % 4), 0, 0, i & 1);
      pulses += int'(done8);
      if (i == 7) check("done8_8th", 32'(done8), 1);
    end
    check("pulses8", pulses, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 19) == 0) ? 0 : 1;
      e = ($urandom_range(0, 3) == 0) ? 0 : 1;
      m = ($urandom_range(0, 5) == 0) ? 1 : int'($urandom_range(0, 7));
      step(r, e, m, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
